// File: rtl/elixirchip_es1_spu_op_reg_driver_pkg.sv
// -----------------------------------------------------------------------------
// elixirchip_es1_spu_op_reg_driver_pkg
// Shared definitions for the spu_op_reg stimulus driver:
//   state_t      - sequencer phases
//   LFSR_POLY    - Galois feedback mask (taps 32,22,2,1)
//   DEFAULT_SEED - seed used when none is supplied
//   lfsr_step()  - one right-shifting Galois step
//   seed_fix()   - maps the forbidden all-zero seed to 1
// -----------------------------------------------------------------------------
package elixirchip_es1_spu_op_reg_driver_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WALK   = 3'd1,
    GAP    = 3'd2,
    RANDOM = 3'd3,
    CLEAR  = 3'd4,
    DRAIN  = 3'd5,
    DONE   = 3'd6
  } state_t;

  localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
  localparam logic [31:0] DEFAULT_SEED = 32'h0000_0001;

  // Right-shifting Galois form: the bit shifted out selects the feedback.
  function automatic logic [31:0] lfsr_step(input logic [31:0] x);
    return {1'b0, x[31:1]} ^ (x[0] ? LFSR_POLY : 32'h0000_0000);
  endfunction

  // An all-zero state would lock the LFSR, so zero is replaced by one.
  function automatic logic [31:0] seed_fix(input logic [31:0] s);
    return (s == 32'h0000_0000) ? 32'h0000_0001 : s;
  endfunction

endpackage

// File: rtl/elixirchip_es1_lfsr32.sv
// -----------------------------------------------------------------------------
// elixirchip_es1_lfsr32
// 32-bit Galois LFSR that advances one step per enabled clock.
// Ports:
//   reset - synchronous active-high, loads seed (0 replaced by 1)
//   clk   - clock
//   cke   - step enable
//   seed  - reload value
//   q     - current LFSR state (registered)
// -----------------------------------------------------------------------------
module elixirchip_es1_lfsr32
  import elixirchip_es1_spu_op_reg_driver_pkg::*;
(
  input  logic        reset,
  input  logic        clk,
  input  logic        cke,
  input  logic [31:0] seed,
  output logic [31:0] q
);

  // LFSR state register: reseed on reset, step when enabled, else hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= seed_fix(seed);
    end else if (cke) begin
      q <= lfsr_step(q);
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/elixirchip_es1_spu_op_reg_driver.sv
// -----------------------------------------------------------------------------
// elixirchip_es1_spu_op_reg_driver
// Deterministic stimulus source for the spu_op_reg register-op path.
// Sequence: IDLE -> WALK (walking ones) -> GAP (inverted hold, invalid)
//           -> RANDOM (LFSR driven) -> CLEAR -> DRAIN -> DONE (sticky).
// Ports:
//   reset   - synchronous active-high reset (has priority over cke)
//   clk     - clock
//   cke     - clock enable; nothing advances while low
//   s_data  - data to DUT (registered)
//   s_clear - clear request to DUT (registered)
//   s_valid - valid to DUT (registered)
//   done    - sequence finished, sticky until reset (registered)
// Build option:
//   ELIXIRCHIP_ES1_SPU_OP_REG_DRIVER_XDATA_EN - drive s_data to all-X on every
//   cycle where s_valid=0 and s_clear=0.
// -----------------------------------------------------------------------------
module elixirchip_es1_spu_op_reg_driver
  import elixirchip_es1_spu_op_reg_driver_pkg::*;
#(
  parameter int          LATENCY    = 1,
  parameter int          DATA_BITS  = 8,
  parameter type         data_t     = logic [DATA_BITS-1:0],
  parameter logic [31:0] SEED       = DEFAULT_SEED,
  parameter int          NUM_RANDOM = 64
) (
  input  logic  reset,
  input  logic  clk,
  input  logic  cke,
  output data_t s_data,
  output logic  s_clear,
  output logic  s_valid,
  output logic  done
);

  localparam int MAX_A   = (DATA_BITS > NUM_RANDOM) ? DATA_BITS : NUM_RANDOM;
  localparam int MAX_LEN = (MAX_A > LATENCY + 2) ? MAX_A : LATENCY + 2;
  localparam int CNT_W   = $clog2(MAX_LEN) + 1;

  localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(DATA_BITS - 1);
  localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(LATENCY);
  localparam logic [CNT_W-1:0] RAND_LAST = CNT_W'(NUM_RANDOM - 1);
  localparam logic [CNT_W-1:0] DRN_LAST  = CNT_W'(LATENCY);

  // Inverse of the final walking-ones word, shown while the DUT must hold.
  localparam data_t GAP_DATA = ~(data_t'(1'b1) << (DATA_BITS - 1));

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic [31:0]        lfsr_q_s;
  logic [31:0]        lfsr_view_s;
  logic               lfsr_en_s;
  data_t              rnd_data_s;
  logic               rnd_valid_s;
  logic               rnd_clear_s;

  // LFSR value replicated (or truncated) to the data width.
  function automatic data_t fill(input logic [31:0] x);
    data_t d;
    for (int i = 0; i < DATA_BITS; i++) begin
      d[i] = x[i % 32];
    end
    return d;
  endfunction

  // Data shown on cycles where neither valid nor clear is asserted.
  function automatic data_t quiet_data(input data_t d);
`ifdef ELIXIRCHIP_ES1_SPU_OP_REG_DRIVER_XDATA_EN
    quiet_data = 'x;
`else
    quiet_data = d;
`endif
  endfunction

  // The LFSR advances on every cke cycle spent in RANDOM or CLEAR.
  assign lfsr_en_s = cke & ((state_r == RANDOM) || (state_r == CLEAR));

  elixirchip_es1_lfsr32 u_lfsr (
    .reset (reset),
    .clk   (clk),
    .cke   (lfsr_en_s),
    .seed  (SEED),
    .q     (lfsr_q_s)
  );

  // Value the LFSR will hold after this edge, so the registered outputs
  // always match the LFSR contents during the cycle they are presented.
  assign lfsr_view_s = (state_r == RANDOM) ? lfsr_step(lfsr_q_s) : lfsr_q_s;

  // Random-phase output decode; valid and clear are independent bits.
  always_comb begin
    rnd_valid_s = lfsr_view_s[0];
    rnd_clear_s = (lfsr_view_s[7:4] == 4'h0);
    if (!rnd_valid_s && !rnd_clear_s) begin
      rnd_data_s = quiet_data(fill(lfsr_view_s));
    end else begin
      rnd_data_s = fill(lfsr_view_s);
    end
  end

  // Sequencer with registered outputs; reset wins over cke.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      cnt_r   <= '0;
      s_data  <= '0;
      s_clear <= 1'b0;
      s_valid <= 1'b0;
      done    <= 1'b0;
    end else if (cke) begin
      case (state_r)
        IDLE: begin
          state_r <= WALK;
          cnt_r   <= '0;
          s_data  <= data_t'(1'b1);
          s_valid <= 1'b1;
          s_clear <= 1'b0;
        end
        WALK: begin
          if (cnt_r == WALK_LAST) begin
            state_r <= GAP;
            cnt_r   <= '0;
            s_data  <= quiet_data(GAP_DATA);
            s_valid <= 1'b0;
          end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
            s_data  <= s_data << 1;
          end
        end
        GAP: begin
          if (cnt_r == GAP_LAST) begin
            cnt_r <= '0;
            if (NUM_RANDOM > 0) begin
              state_r <= RANDOM;
              s_data  <= rnd_data_s;
              s_valid <= rnd_valid_s;
              s_clear <= rnd_clear_s;
            end else begin
              state_r <= CLEAR;
              s_data  <= fill(lfsr_view_s);
              s_valid <= 1'b1;
              s_clear <= 1'b1;
            end
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        RANDOM: begin
          if (cnt_r == RAND_LAST) begin
            state_r <= CLEAR;
            cnt_r   <= '0;
            s_data  <= fill(lfsr_view_s);
            s_valid <= 1'b1;
            s_clear <= 1'b1;
          end else begin
            cnt_r   <= cnt_r + CNT_W'(1);
            s_data  <= rnd_data_s;
            s_valid <= rnd_valid_s;
            s_clear <= rnd_clear_s;
          end
        end
        CLEAR: begin
          state_r <= DRAIN;
          cnt_r   <= '0;
          s_data  <= quiet_data('0);
          s_valid <= 1'b0;
          s_clear <= 1'b0;
        end
        DRAIN: begin
          if (cnt_r == DRN_LAST) begin
            state_r <= DONE;
            cnt_r   <= '0;
            done    <= 1'b1;
          end else begin
            cnt_r <= cnt_r + CNT_W'(1);
          end
        end
        DONE: begin
          done <= 1'b1;
        end
        default: begin
          state_r <= IDLE;
          cnt_r   <= '0;
          s_data  <= '0;
          s_valid <= 1'b0;
          s_clear <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_elixirchip_es1_spu_op_reg_driver.sv
// -----------------------------------------------------------------------------
// tb_elixirchip_es1_spu_op_reg_driver
// Directed bench for the spu_op_reg stimulus driver (default build).
// An expected-output table for the whole sequence is built from an
// independent LFSR model; each clock the expectation for the coming edge
// is queued and then compared against the DUT one time unit after the edge.
// -----------------------------------------------------------------------------
module tb_elixirchip_es1_spu_op_reg_driver;

  localparam int LAST_STEP = 78;

  logic       reset;
  logic       clk;
  logic       cke;
  logic [7:0] s_data;
  logic       s_clear;
  logic       s_valid;
  logic       done;

  elixirchip_es1_spu_op_reg_driver #(
    .LATENCY    (1),
    .DATA_BITS  (8),
    .SEED       (32'h0000_0001),
    .NUM_RANDOM (64)
  ) dut (
    .reset   (reset),
    .clk     (clk),
    .cke     (cke),
    .s_data  (s_data),
    .s_clear (s_clear),
    .s_valid (s_valid),
    .done    (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {done, clear, valid, data} after the n-th cke edge since reset release
  logic [10:0] gen [0:LAST_STEP];
  logic [10:0] exp_q [$];
  int vectors     = 0;
  int miscompares = 0;
  int step        = 0;
  int both_seen   = 0;

  function automatic logic [31:0] model_step(input logic [31:0] x);
    logic [31:0] n;
    n = x >> 1;
    if (x[0]) n = n ^ 32'h8020_0003;
    return n;
  endfunction

  task automatic build_table();
    logic [31:0] r;
    r = 32'h0000_0001;
    gen[0] = 11'h000;
    for (int k = 1; k <= 8; k++) gen[k] = {3'b001, 8'(32'd1 << (k - 1))};
    gen[9]  = {3'b000, 8'h7F};
    gen[10] = {3'b000, 8'h7F};
    for (int k = 11; k <= 74; k++) begin
      gen[k] = {1'b0, (r[7:4] == 4'h0), r[0], r[7:0]};
      r = model_step(r);
    end
    gen[75] = {3'b011, r[7:0]};
    gen[76] = 11'h000;
    gen[77] = 11'h000;
    gen[78] = {3'b100, 8'h00};
  endtask

  task automatic tick(input logic rst, input logic en, input string tag);
    logic [10:0] e;
    logic [10:0] o;
    reset = rst;
    cke   = en;
    if (rst) step = 0;
    else if (en && step < LAST_STEP) step = step + 1;
    exp_q.push_back(gen[step]);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    o = {done, s_clear, s_valid, s_data};
    vectors++;
    assert (o === e) else begin
      miscompares++;
      $error("FAIL %s step %0d: observed %h expected %h", tag, step, o, e);
    end
    if (step >= 11 && step <= 74 && s_clear === 1'b1 && s_valid === 1'b1) both_seen++;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int guard;
    logic en;
    build_table();
    reset = 1'b1;
    cke   = 1'b1;

    // reset state
    repeat (3) tick(1'b1, 1'b1, "reset");
    tick(1'b1, 1'b0, "reset_cke0");

    // walking ones up to 04, then hold 3 cycles with cke low
    repeat (3) tick(1'b0, 1'b1, "walk");
    repeat (3) tick(1'b0, 1'b0, "hold");

    // remainder of the sequence, then check done stays high
    guard = 0;
    while (step < LAST_STEP && guard < 200) begin
      tick(1'b0, 1'b1, "run");
      guard++;
    end
    repeat (3) tick(1'b0, 1'b1, "done_sticky");

    vectors++;
    assert (both_seen > 0) else begin
      miscompares++;
      $error("FAIL clear_and_valid: observed %0d cycles expected >0", both_seen);
    end

    // reset held with cke low still resets
    tick(1'b1, 1'b0, "reset_over_cke");

    // rerun with random cke gaps up to random cycle 20
    guard = 0;
    while (step < 31 && guard < 500) begin
      en = ($urandom_range(0, 3) != 0);
      tick(1'b0, en, "rerun");
      guard++;
    end
    vectors++;
    assert (step == 31) else begin
      miscompares++;
      $error("FAIL rerun_budget: observed step %0d expected 31", step);
    end

    // reset mid random phase
    tick(1'b1, 1'b1, "midreset");

    // full rerun must reproduce the same stream
    guard = 0;
    while (step < LAST_STEP && guard < 200) begin
      tick(1'b0, 1'b1, "rerun_full");
      guard++;
    end
    repeat (2) tick(1'b0, 1'b1, "rerun_done");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
